// File: rtl/veer_types.sv
// ----------------------------------------------------------------------------
// veer_types : shared trace types
//
// Holds the per-entry FIFO record used by trace_lane_serializer. The struct
// is sized for the widest supported packet (TRACE_MAX_LANES lanes). Narrower
// configurations leave the upper lanes at zero.
//
// Optional build macro: RV_TRACE_TIMESTAMP_EN adds a 32-bit push timestamp
// field to every entry.
// ----------------------------------------------------------------------------
package veer_types;

   localparam int TRACE_MAX_LANES  = 8;
   localparam int TRACE_MAX_LANE_W = 3;

   typedef struct packed {
      logic [TRACE_MAX_LANES-1:0]        valid;
      logic [TRACE_MAX_LANES-1:0][31:0]  insn;
      logic [TRACE_MAX_LANES-1:0][31:0]  addr;
      logic [TRACE_MAX_LANES-1:0]        exception;
      logic [TRACE_MAX_LANES-1:0]        interrupt;
      logic [4:0]                        ecause;
      logic [31:0]                       tval;
      logic                              gap;
`ifdef RV_TRACE_TIMESTAMP_EN
      logic [31:0]                       timestamp;
`endif
   } trace_lane_pkt_t;

   // Width of a lane index; a single-lane build still needs one bit.
   function automatic int trace_lane_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/trace_lane_pick.sv
// ----------------------------------------------------------------------------
// trace_lane_pick : next-lane selector for the trace serializer
//
// Finds the lowest set bit of i_valid at an index >= i_ptr and reports
// whether any valid lane lies above it.
//
// Ports:
//   i_valid  in  LANES   per-lane valid bits of the head entry
//   i_ptr    in  LANE_W  first lane index still to be emitted
//   o_sel    out LANE_W  selected lane
//   o_last   out 1       no valid lane above o_sel
//
// Optional build macro RV_TRACE_TIMESTAMP_EN: not used in this file.
// ----------------------------------------------------------------------------
module trace_lane_pick
   import veer_types::*;
#(
   parameter  int LANES  = 3,
   localparam int LANE_W = trace_lane_w(LANES)
)(
   input  logic [LANES-1:0]  i_valid,
   input  logic [LANE_W-1:0] i_ptr,
   output logic [LANE_W-1:0] o_sel,
   output logic              o_last
);

   logic w_found;
   logic w_hit;

   // Priority search from the lane pointer upward, then a scan for later lanes.
   always_comb begin
      w_found = 1'b0;
      w_hit   = 1'b0;
      o_sel   = '0;
      o_last  = 1'b1;
      for (int k = 0; k < LANES; k++) begin
         w_hit   = i_valid[k] && (k >= int'(i_ptr)) && !w_found;
         o_sel   = w_hit ? LANE_W'(k) : o_sel;
         w_found = w_found | w_hit;
      end
      for (int k = 0; k < LANES; k++) begin
         o_last = o_last && !(i_valid[k] && (k > int'(o_sel)));
      end
   end

endmodule

// File: rtl/trace_lane_serializer.sv
// ----------------------------------------------------------------------------
// trace_lane_serializer : multi-lane retire trace packet -> per-record stream
//
// Buffers whole retire packets in a DEPTH-entry FIFO and emits one retired
// instruction record per cycle over valid/ready. Packets arriving while the
// FIFO is full (and the head is not retiring this cycle) are dropped, counted
// in a saturating counter, and the next stored packet is flagged with a gap.
//
// Ports:
//   clk, rst_l (sync active-low), flush
//   in_valid/in_insn/in_addr/in_exception/in_interrupt : per-lane packet
//   in_ecause/in_tval  : packet-wide cause and tval
//   out_valid/out_ready: record handshake
//   out_lane/out_insn/out_addr/out_exception/out_interrupt/out_ecause/
//   out_tval/out_gap/out_last : current record
//   fifo_level, drop_cnt : status
//   out_timestamp (only with RV_TRACE_TIMESTAMP_EN) : push-time cycle count
//
// Optional build macro RV_TRACE_TIMESTAMP_EN adds a free-running cycle
// counter, captures it per entry and exposes it on out_timestamp.
// ----------------------------------------------------------------------------
module trace_lane_serializer
   import veer_types::*;
#(
   parameter  int LANES  = 3,
   parameter  int DEPTH  = 4,
   parameter  int CNT_W  = 16,
   localparam int LANE_W = trace_lane_w(LANES),
   localparam int LVL_W  = $clog2(DEPTH + 1)
)(
   input  logic                  clk,
   input  logic                  rst_l,
   input  logic                  flush,
   input  logic [LANES-1:0]      in_valid,
   input  logic [LANES*32-1:0]   in_insn,
   input  logic [LANES*32-1:0]   in_addr,
   input  logic [LANES-1:0]      in_exception,
   input  logic [LANES-1:0]      in_interrupt,
   input  logic [4:0]            in_ecause,
   input  logic [31:0]           in_tval,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANE_W-1:0]     out_lane,
   output logic [31:0]           out_insn,
   output logic [31:0]           out_addr,
   output logic                  out_exception,
   output logic                  out_interrupt,
   output logic [4:0]            out_ecause,
   output logic [31:0]           out_tval,
   output logic                  out_gap,
   output logic                  out_last,
`ifdef RV_TRACE_TIMESTAMP_EN
   output logic [31:0]           out_timestamp,
`endif
   output logic [LVL_W-1:0]      fifo_level,
   output logic [CNT_W-1:0]      drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [PTR_W:0]          r_wr_ptr;
   logic [PTR_W:0]          r_rd_ptr;
   trace_lane_pkt_t         r_mem [DEPTH];
   logic [LANE_W-1:0]       r_lane_ptr;
   logic                    r_pending_gap;
   logic [CNT_W-1:0]        r_drop_cnt;
`ifdef RV_TRACE_TIMESTAMP_EN
   logic [31:0]             r_cycle;
`endif

   trace_lane_pkt_t         w_head;
   trace_lane_pkt_t         w_pkt;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_fire;
   logic                    w_pop;
   logic                    w_any_in;
   logic                    w_push;
   logic                    w_ovf;
   logic                    w_last;
   logic                    w_flag;
   logic [LANE_W-1:0]       w_sel;
   logic [TRACE_MAX_LANE_W-1:0] w_sel_idx;
   logic [PTR_W-1:0]        w_waddr;
   logic                    w_unused_valid;

   assign w_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_fire    = !w_empty && out_ready;
   assign w_pop     = w_fire && w_last;
   assign w_any_in  = |in_valid;
   // Flush empties the FIFO first, so its packet always finds room.
   assign w_push    = w_any_in && (flush || !w_full || w_pop);
   assign w_ovf     = w_any_in && !flush && w_full && !w_pop;
   assign w_waddr   = flush ? '0 : r_wr_ptr[PTR_W-1:0];
   assign w_sel_idx = TRACE_MAX_LANE_W'(w_sel);
   assign w_unused_valid = ^w_head.valid;

   assign fifo_level = LVL_W'(r_wr_ptr - r_rd_ptr);
   assign drop_cnt   = r_drop_cnt;

   trace_lane_pick #(
      .LANES (LANES)
   ) u_pick (
      .i_valid (w_head.valid[LANES-1:0]),
      .i_ptr   (r_lane_ptr),
      .o_sel   (w_sel),
      .o_last  (w_last)
   );

   // Pack the incoming lanes into an entry; unused upper lanes stay zero.
   always_comb begin
      w_pkt = '0;
      for (int k = 0; k < LANES; k++) begin
         w_pkt.valid[k]     = in_valid[k];
         w_pkt.insn[k]      = in_insn[32*k +: 32];
         w_pkt.addr[k]      = in_addr[32*k +: 32];
         w_pkt.exception[k] = in_exception[k];
         w_pkt.interrupt[k] = in_interrupt[k];
      end
      w_pkt.ecause = in_ecause;
      w_pkt.tval   = in_tval;
      w_pkt.gap    = r_pending_gap;
`ifdef RV_TRACE_TIMESTAMP_EN
      w_pkt.timestamp = r_cycle;
`endif
   end

   // Present the selected head lane; everything reads zero while empty.
   always_comb begin
      if (!w_empty) begin
         w_flag        = w_head.exception[w_sel_idx] || w_head.interrupt[w_sel_idx];
         out_valid     = 1'b1;
         out_lane      = w_sel;
         out_insn      = w_head.insn[w_sel_idx];
         out_addr      = w_head.addr[w_sel_idx];
         out_exception = w_head.exception[w_sel_idx];
         out_interrupt = w_head.interrupt[w_sel_idx];
         out_ecause    = w_flag ? w_head.ecause : 5'd0;
         out_tval      = w_flag ? w_head.tval : 32'd0;
         // The lane pointer is only zero before the first record of an entry.
         out_gap       = w_head.gap && (r_lane_ptr == '0);
         out_last      = w_last;
`ifdef RV_TRACE_TIMESTAMP_EN
         out_timestamp = w_head.timestamp;
`endif
      end else begin
         w_flag        = 1'b0;
         out_valid     = 1'b0;
         out_lane      = '0;
         out_insn      = 32'd0;
         out_addr      = 32'd0;
         out_exception = 1'b0;
         out_interrupt = 1'b0;
         out_ecause    = 5'd0;
         out_tval      = 32'd0;
         out_gap       = 1'b0;
         out_last      = 1'b0;
`ifdef RV_TRACE_TIMESTAMP_EN
         out_timestamp = 32'd0;
`endif
      end
   end

   // FIFO pointers, lane pointer, gap tracking and drop counter.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_lane_ptr    <= '0;
         r_pending_gap <= 1'b0;
         r_drop_cnt    <= '0;
      end else begin
         if (flush) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= w_push ? (PTR_W+1)'(1) : '0;
            r_lane_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
               r_rd_ptr   <= r_rd_ptr + (PTR_W+1)'(1);
               r_lane_ptr <= '0;
            end else if (w_fire) begin
               r_lane_ptr <= w_sel + LANE_W'(1);
            end
         end
         if (w_push) begin
            r_pending_gap <= 1'b0;
         end else if (w_ovf) begin
            r_pending_gap <= 1'b1;
         end
         if (w_ovf && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end
      end
   end

   // Entry storage write port; contents need no reset since pointers gate them.
   always_ff @(posedge clk) begin
      if (rst_l && w_push) begin
         r_mem[w_waddr] <= w_pkt;
      end
   end

`ifdef RV_TRACE_TIMESTAMP_EN
   // Free-running cycle counter sampled into each entry at push.
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_cycle <= 32'd0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_trace_lane_serializer.sv
module tb_trace_lane_serializer;

   localparam int LANES  = 3;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 2;
   localparam int LANE_W = 2;
   localparam int LVL_W  = 3;

   logic                 clk;
   logic                 rst_l;
   logic                 flush;
   logic [LANES-1:0]     in_valid;
   logic [LANES*32-1:0]  in_insn;
   logic [LANES*32-1:0]  in_addr;
   logic [LANES-1:0]     in_exception;
   logic [LANES-1:0]     in_interrupt;
   logic [4:0]           in_ecause;
   logic [31:0]          in_tval;
   logic                 out_valid;
   logic                 out_ready;
   logic [LANE_W-1:0]    out_lane;
   logic [31:0]          out_insn;
   logic [31:0]          out_addr;
   logic                 out_exception;
   logic                 out_interrupt;
   logic [4:0]           out_ecause;
   logic [31:0]          out_tval;
   logic                 out_gap;
   logic                 out_last;
`ifdef RV_TRACE_TIMESTAMP_EN
   logic [31:0]          out_timestamp;
`endif
   logic [LVL_W-1:0]     fifo_level;
   logic [CNT_W-1:0]     drop_cnt;

   trace_lane_serializer #(
      .LANES (LANES),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_l         (rst_l),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_insn       (in_insn),
      .in_addr       (in_addr),
      .in_exception  (in_exception),
      .in_interrupt  (in_interrupt),
      .in_ecause     (in_ecause),
      .in_tval       (in_tval),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_lane      (out_lane),
      .out_insn      (out_insn),
      .out_addr      (out_addr),
      .out_exception (out_exception),
      .out_interrupt (out_interrupt),
      .out_ecause    (out_ecause),
      .out_tval      (out_tval),
      .out_gap       (out_gap),
      .out_last      (out_last),
`ifdef RV_TRACE_TIMESTAMP_EN
      .out_timestamp (out_timestamp),
`endif
      .fifo_level    (fifo_level),
      .drop_cnt      (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected record stream: each stored packet expands into its lanes.
   typedef struct {
      int          lane;
      logic [31:0] insn;
      logic [31:0] addr;
      logic        exc;
      logic        intr;
      logic [4:0]  ecause;
      logic [31:0] tval;
      logic        gap;
      logic        last;
   } rec_t;

   rec_t exp_q[$];
   int   n_entries;
   int   drop_model;
   bit   pend_model;
   bit   started;
   int   vectors;
   int   miscompares;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_push();
      int  last_k;
      bit  first;
      rec_t r;
      last_k = -1;
      first  = 1'b1;
      for (int k = 0; k < LANES; k++) if (in_valid[k]) last_k = k;
      for (int k = 0; k < LANES; k++) begin
         if (in_valid[k]) begin
            r.lane   = k;
            r.insn   = in_insn[32*k +: 32];
            r.addr   = in_addr[32*k +: 32];
            r.exc    = in_exception[k];
            r.intr   = in_interrupt[k];
            r.ecause = (in_exception[k] || in_interrupt[k]) ? in_ecause : 5'd0;
            r.tval   = (in_exception[k] || in_interrupt[k]) ? in_tval : 32'd0;
            r.gap    = first ? pend_model : 1'b0;
            r.last   = (k == last_k);
            first    = 1'b0;
            exp_q.push_back(r);
         end
      end
      n_entries++;
      pend_model = 1'b0;
   endtask

   task automatic model_step();
      bit was_full;
      bit popped;
      if (!rst_l) begin
         exp_q.delete();
         n_entries  = 0;
         drop_model = 0;
         pend_model = 1'b0;
         started    = 1'b1;
      end else if (flush) begin
         exp_q.delete();
         n_entries = 0;
         if (|in_valid) model_push();
      end else begin
         was_full = (n_entries == DEPTH);
         popped   = 1'b0;
         if (exp_q.size() > 0 && out_ready) begin
            if (exp_q[0].last) begin
               popped = 1'b1;
               n_entries--;
            end
            void'(exp_q.pop_front());
         end
         if (|in_valid) begin
            if (!was_full || popped) begin
               model_push();
            end else begin
               if (drop_model < (2**CNT_W - 1)) drop_model++;
               pend_model = 1'b1;
            end
         end
      end
   endtask

   // Reference model advances on every active edge using the applied inputs.
   initial begin
      started = 1'b0;
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor compares the DUT against the model head away from the edge.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            check("fifo_level", 64'(fifo_level), 64'(n_entries));
            check("drop_cnt", 64'(drop_cnt), 64'(drop_model));
            if (exp_q.size() > 0) begin
               check("out_valid", 64'(out_valid), 64'd1);
               check("out_lane", 64'(out_lane), 64'(exp_q[0].lane));
               check("out_insn", 64'(out_insn), 64'(exp_q[0].insn));
               check("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
               check("out_exc_int", 64'({out_exception, out_interrupt}),
                     64'({exp_q[0].exc, exp_q[0].intr}));
               check("out_ecause", 64'(out_ecause), 64'(exp_q[0].ecause));
               check("out_tval", 64'(out_tval), 64'(exp_q[0].tval));
               check("out_gap", 64'(out_gap), 64'(exp_q[0].gap));
               check("out_last", 64'(out_last), 64'(exp_q[0].last));
            end else begin
               check("idle_ctl", 64'({out_valid, out_lane, out_exception, out_interrupt,
                                      out_ecause, out_gap, out_last}), 64'd0);
               check("idle_data", {out_insn, out_addr}, 64'd0);
               check("idle_tval", 64'(out_tval), 64'd0);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      in_valid = '0;
      flush    = 1'b0;
   endtask

   task automatic rand_pkt(input logic [LANES-1:0] v);
      in_valid = v;
      for (int k = 0; k < LANES; k++) begin
         in_insn[32*k +: 32] = $urandom;
         in_addr[32*k +: 32] = $urandom;
      end
      in_exception = LANES'($urandom) & LANES'($urandom);
      in_interrupt = LANES'($urandom) & LANES'($urandom) & LANES'($urandom);
      in_ecause    = 5'($urandom);
      in_tval      = $urandom;
   endtask

   initial begin
      int ready_pct;
      vectors      = 0;
      miscompares  = 0;
      rst_l        = 1'b0;
      flush        = 1'b0;
      out_ready    = 1'b0;
      in_valid     = '0;
      in_insn      = '0;
      in_addr      = '0;
      in_exception = '0;
      in_interrupt = '0;
      in_ecause    = 5'd0;
      in_tval      = 32'd0;
      tick(2);
      rst_l = 1'b1;
      tick(1);

      // Two-lane packet, lanes 0 and 2.
      out_ready = 1'b1;
      rand_pkt(3'b101);
      in_exception = '0;
      in_interrupt = '0;
      in_insn[31:0]  = 32'h11;
      in_insn[95:64] = 32'h33;
      tick(1);
      idle();
      tick(4);

      // Overflow by one, then a gapped packet once drained.
      out_ready = 1'b0;
      repeat (5) begin
         rand_pkt(LANES'($urandom_range(1, 7)));
         tick(1);
      end
      idle();
      tick(2);
      out_ready = 1'b1;
      tick(15);
      rand_pkt(3'b011);
      tick(1);
      idle();
      tick(4);

      // Full FIFO of single-lane entries, push while the head retires.
      out_ready = 1'b0;
      repeat (4) begin
         rand_pkt(3'b001);
         tick(1);
      end
      out_ready = 1'b1;
      rand_pkt(3'b110);
      tick(1);
      idle();
      out_ready = 1'b0;
      tick(2);
      out_ready = 1'b1;
      tick(12);

      // Exception on lane 1 only.
      rand_pkt(3'b011);
      in_exception = 3'b010;
      in_interrupt = 3'b000;
      in_ecause    = 5'd2;
      in_tval      = 32'hDEAD;
      tick(1);
      idle();
      tick(4);

      // Flush with three entries buffered and a new packet alongside.
      out_ready = 1'b0;
      repeat (3) begin
         rand_pkt(3'b111);
         tick(1);
      end
      rand_pkt(3'b100);
      flush = 1'b1;
      tick(1);
      idle();
      tick(1);
      out_ready = 1'b1;
      tick(6);

      // Drive the drop counter into saturation, then reset.
      out_ready = 1'b0;
      repeat (9) begin
         rand_pkt(3'b010);
         tick(1);
      end
      idle();
      tick(1);
      rst_l = 1'b0;
      tick(1);
      rst_l = 1'b1;
      tick(2);

      // Randomised traffic with varying back-pressure.
      ready_pct = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) ready_pct = $urandom_range(10, 100);
         out_ready = ($urandom_range(1, 100) <= ready_pct);
         flush     = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 2) != 0) rand_pkt(LANES'($urandom));
         else in_valid = '0;
         rst_l = ($urandom_range(0, 999) != 0);
         tick(1);
      end
      rst_l = 1'b1;
      idle();
      out_ready = 1'b1;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
